// File: rtl/vblank_update_arbiter_if.sv
// Requester-side write handshake for the display register bank.
// Requesters drive the master side; the arbiter answers with a one-hot grant.
interface vblank_update_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 10
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        gnt;

  modport master (output req, output req_addr, output req_data, input gnt);
  modport slave  (input req, input req_addr, input req_data, output gnt);
endinterface

// File: rtl/vblank_update_arbiter.sv
// Round-robin write arbiter into a shadow register bank, opened only during vertical blanking;
// the shadow is copied to the active bank once per frame on the guard line before row 0.
module vblank_update_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 10,
  parameter int V_VISIBLE = 480,
  parameter int V_TOTAL   = 525
) (
  input  logic                            vga_clock,
  input  logic                            vga_reset_n,
  input  logic [9:0]                      vga_row,
  input  logic [9:0]                      vga_col,
  vblank_update_arbiter_if.slave          bus,
  output logic [(2**ADDR_W)*DATA_W-1:0]   reg_active,
  output logic                            update_win,
  output logic                            commit_pulse,
  output logic [7:0]                      frame_writes
);

  localparam int         DEPTH     = 2**ADDR_W;
  localparam int         PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [9:0] ROW_OPEN  = 10'(V_VISIBLE);
  localparam logic [9:0] ROW_GUARD = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {ACTIVE, UPDATE, COMMIT} state_t;

  state_t                     state_q;
  logic [PTR_W-1:0]           rr_ptr_q;
  logic [7:0]                 wr_cnt_q;
  logic [7:0]                 frame_writes_q;
  logic                       commit_pulse_q;
  logic                       update_win_q;
  logic [DATA_W-1:0]          shadow_q [DEPTH];
  logic [DEPTH*DATA_W-1:0]    active_q;

  logic [N_REQ-1:0]           gnt_d;
  logic [PTR_W-1:0]           sel_d;
  logic [PTR_W-1:0]           idx_d;
  logic                       found_d;
  logic [ADDR_W-1:0]          wr_addr_d;
  logic [DATA_W-1:0]          wr_data_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // The guard row is excluded even while in UPDATE, so the shadow is frozen on the copy edge.
  always_comb begin
    gnt_d   = '0;
    sel_d   = '0;
    idx_d   = '0;
    found_d = 1'b0;
    if (state_q == UPDATE && vga_row != ROW_GUARD) begin
      for (int k = 1; k <= N_REQ; k++) begin
        idx_d = PTR_W'((int'(rr_ptr_q) + k) % N_REQ);
        if (!found_d && bus.req[idx_d]) begin
          found_d      = 1'b1;
          gnt_d[idx_d] = 1'b1;
          sel_d        = idx_d;
        end
      end
    end
    wr_addr_d = bus.req_addr[int'(sel_d)*ADDR_W +: ADDR_W];
    wr_data_d = bus.req_data[int'(sel_d)*DATA_W +: DATA_W];
  end

  // The bank copy happens on the edge leaving UPDATE; COMMIT is the one-cycle pulse slot.
  always_ff @(posedge vga_clock or negedge vga_reset_n) begin
    if (!vga_reset_n) begin
      state_q        <= ACTIVE;
      rr_ptr_q       <= PTR_W'(N_REQ - 1);
      wr_cnt_q       <= '0;
      frame_writes_q <= '0;
      commit_pulse_q <= 1'b0;
      update_win_q   <= 1'b0;
      active_q       <= '0;
      for (int k = 0; k < DEPTH; k++) shadow_q[k] <= '0;
    end else begin
      commit_pulse_q <= 1'b0;
      if (found_d) begin
        shadow_q[wr_addr_d] <= wr_data_d;
        rr_ptr_q            <= sel_d;
        wr_cnt_q            <= sat_inc(wr_cnt_q);
      end
      case (state_q)
        ACTIVE: begin
          if (vga_row == ROW_OPEN && vga_col == 10'd0) begin
            state_q      <= UPDATE;
            update_win_q <= 1'b1;
          end
        end
        UPDATE: begin
          if (vga_row == ROW_GUARD && vga_col == 10'd0) begin
            state_q        <= COMMIT;
            update_win_q   <= 1'b0;
            commit_pulse_q <= 1'b1;
            frame_writes_q <= wr_cnt_q;
            wr_cnt_q       <= '0;
            for (int k = 0; k < DEPTH; k++) active_q[k*DATA_W +: DATA_W] <= shadow_q[k];
          end
        end
        COMMIT:  state_q <= ACTIVE;
        default: state_q <= ACTIVE;
      endcase
    end
  end

  assign bus.gnt      = gnt_d;
  assign reg_active   = active_q;
  assign update_win   = update_win_q;
  assign commit_pulse = commit_pulse_q;
  assign frame_writes = frame_writes_q;

endmodule
